vga_patterngen_multi: RTL and testbench
=======================================

# vga_patterngen_multi

Parametrised, multi-mode test-pattern generator for the VGA output path. It consumes the timing strobes from the VGA timing generator (DE, active-low HSync and VSync) and produces one registered colour word per pixel. It selects one of four patterns per frame: horizontal ramp, colour bars, checkerboard and vertical grey gradient. It replaces the single-pattern ramp generator and adds colour-depth and geometry parameters, pipeline-aligned sync outputs, and asynchronous reset.

## Interface
- COLOR_W, 3, bits per colour channel
- STEP, 31, active pixels per ramp decrement
- BAR_W, 80, pixels per colour bar
- CHECK_LOG2, 5, log2 of checker square size in pixels/lines
- GRAD_SHIFT, 4, log2 of lines per vertical-gradient level
- H_CTR_W, 11, pixel counter width
- V_CTR_W, 10, line counter width

Ports:
- i_Clk  in  1  pixel clock
- i_Rst_n  in  1  reset, asynchronous, active-low
- i_DE  in  1  data enable (active video)
- i_HSync  in  1  horizontal sync, active-low
- i_VSync  in  1  vertical sync, active-low
- i_Mode  in  2  requested pattern: 0 RAMP, 1 BARS, 2 CHECKER, 3 VGRAD
- o_DE, o_HSync, o_VSync  out  1 each  inputs delayed one cycle
- o_R, o_G, o_B  out  COLOR_W each  pixel colour

## Operation
- Pixel counter x: clears while i_HSync=0. Increments on each i_DE=1 cycle. Saturates at all-ones.
- Line counter y: clears while i_VSync=0. Increments on each i_DE falling edge (1→0). Saturates at all-ones.
- Mode register: loads i_Mode on the i_VSync falling edge only. Mid-frame changes of i_Mode are ignored until the next frame.
- FULL = all-ones COLOR_W. Colour outputs are forced to 0 whenever the delayed DE is 0.
- RAMP: ramp registers R,G,B load FULL while i_HSync=0, and a step counter clears. During DE the step counter increments. When it reaches STEP-1 it clears and one channel decrements: R if R≠0, else G if G≠0, else B if B≠0. Black saturates.
- BARS: bar index = number of thresholds k·BAR_W (k=1..7) that are ≤ xe, so the index saturates at 7. Indices 0–7 map to white, yellow, cyan, green, magenta, red, blue, black. Each channel is FULL or 0.
- CHECKER: xe[CHECK_LOG2] XOR y[CHECK_LOG2]. Result 0 gives FULL on all channels; result 1 gives black.
- VGRAD: R=G=B=y[GRAD_SHIFT+COLOR_W-1:GRAD_SHIFT]. Wraps naturally.
- xe = x, or x plus the scroll offset when scrolling is enabled (see Configuration).

## Timing
- Latency is 1 cycle. The colour for input cycle n appears at cycle n+1, aligned with o_DE/o_HSync/o_VSync.
- Reset values: o_R/o_G/o_B=0, o_DE=0, o_HSync=1, o_VSync=1, mode=RAMP, x=y=0, step counter=0, ramp registers=FULL, frame counter=0.
- Reset asserted mid-line takes effect immediately. Output is black until the next DE after release.
- HSync low and DE high in the same cycle: HSync clear wins.
- A DE falling edge in the same cycle as VSync low: y stays 0.
- A VSync falling edge during reset is not recorded.

## Configuration
- VGA_PATTERN_SCROLL_EN defined: an H_CTR_W-bit frame counter increments on every i_VSync falling edge and wraps. xe = x + frame counter (mod 2^H_CTR_W), so BARS and CHECKER scroll left by 1 pixel per frame. RAMP and VGRAD are unaffected.
- Undefined: no frame counter, and xe = x.

## Structure
- Package vga_pattern_pkg holds:
  - mode constants MODE_RAMP/BARS/CHECKER/VGRAD;
  - the 8-entry bar colour table as 3-bit RGB on/off flags.
- Sub-module vga_raster_tracker:
  - detects the DE and VSync falling edges;
  - owns x, y and the frame counter;
  - outputs x, y, xe, frame_start.
- The top level holds the mode register, ramp logic, pattern mux and output register.

## Test plan
- COLOR_W=3, STEP=31, mode 0, 640-pixel line: o_R=7 for pixels 0–30 and 6 for pixels 31–61. R reaches 0, then G decrements, then B; the line ends black from pixel 651·… capped at black. o_R=7 again after the next HSync.
- Mode 1, BAR_W=80: pixel 0 → (7,7,7); pixel 79 → white; pixel 80 → (7,7,0); pixel 600 → (0,0,0); pixel 700 → (0,0,0) (saturated index).
- Mode 2, CHECKER_LOG2=5: (x=0,y=0) white; (x=32,y=0) black; (x=32,y=32) white. All outputs are 0 during blanking.
- Switch i_Mode 0→3 mid-frame: the pattern stays RAMP until the VSync falling edge. Next frame, line 16 outputs (1,1,1).
- Assert i_Rst_n=0 mid-line for 3 cycles: all outputs are at reset values asynchronously, and mode returns to RAMP.
- With VGA_PATTERN_SCROLL_EN and mode 1, after 5 frames: the white→yellow transition is at x=75.

Source files
------------

// File: rtl/vga_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_pkg
// Description : Shared mode encoding and colour-bar table for the multi-mode
//               VGA test-pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pattern_pkg;

    // Pattern selection, latched once per frame
    typedef enum logic [1:0] {
        MODE_RAMP    = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_VGRAD   = 2'd3
    } mode_e;

    // Bar colours as {R,G,B} on/off flags; element 0 is the leftmost bar.
    // Order: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000,     // 7 black
        3'b001,     // 6 blue
        3'b100,     // 5 red
        3'b101,     // 4 magenta
        3'b010,     // 3 green
        3'b011,     // 2 cyan
        3'b110,     // 1 yellow
        3'b111      // 0 white
    };

endpackage
`default_nettype wire

// File: rtl/vga_raster_tracker.sv
`default_nettype none
// ============================================================================
// Module      : vga_raster_tracker
// Description : Derives pixel (x) and line (y) positions from the VGA timing
//               strobes, detects the DE and VSync falling edges, and (when
//               VGA_PATTERN_SCROLL_EN is defined) keeps a per-frame counter
//               used as a horizontal scroll offset.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_raster_tracker #(
    parameter int H_CTR_W = 11,
    parameter int V_CTR_W = 10
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_DE,
    input  logic               i_HSync,
    input  logic               i_VSync,
    output logic [H_CTR_W-1:0] o_X,
    output logic [H_CTR_W-1:0] o_Xe,
    output logic [V_CTR_W-1:0] o_Y,
    output logic               o_Frame_Start
);

    logic               r_de_d;
    logic               r_vs_d;
    logic [H_CTR_W-1:0] r_x;
    logic [V_CTR_W-1:0] r_y;
    logic               w_de_fall;
    logic               w_vs_fall;

    // The VSync history resets low so that a sync already low when reset
    // releases (i.e. a falling edge that happened during reset) is not seen.
    assign w_de_fall = r_de_d & ~i_DE;
    assign w_vs_fall = r_vs_d & ~i_VSync;

    // Previous-cycle copies of DE and VSync for edge detection
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_de_d <= 1'b0;
            r_vs_d <= 1'b0;
        end else begin
            r_de_d <= i_DE;
            r_vs_d <= i_VSync;
        end
    end

    // Pixel counter: HSync clear has priority over a coincident DE
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_x <= '0;
        end else if (!i_HSync) begin
            r_x <= '0;
        end else if (i_DE && (r_x != '1)) begin
            r_x <= r_x + H_CTR_W'(1);
        end
    end

    // Line counter: advances at the end of each active line, VSync clear wins
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_y <= '0;
        end else if (!i_VSync) begin
            r_y <= '0;
        end else if (w_de_fall && (r_y != '1)) begin
            r_y <= r_y + V_CTR_W'(1);
        end
    end

`ifdef VGA_PATTERN_SCROLL_EN
    logic [H_CTR_W-1:0] r_frame;

    // Frame counter wraps; it shifts the effective x by one pixel per frame
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_frame <= '0;
        end else if (w_vs_fall) begin
            r_frame <= r_frame + H_CTR_W'(1);
        end
    end

    assign o_Xe = r_x + r_frame;
`else
    assign o_Xe = r_x;
`endif

    assign o_X           = r_x;
    assign o_Y           = r_y;
    assign o_Frame_Start = w_vs_fall;

endmodule
`default_nettype wire

// File: rtl/vga_patterngen_multi.sv
`default_nettype none
// ============================================================================
// Module      : vga_patterngen_multi
// Description : Multi-mode VGA test-pattern generator (ramp, colour bars,
//               checkerboard, vertical grey gradient). One-cycle latency with
//               sync strobes delayed to stay aligned with the colour word.
//               Optional macro VGA_PATTERN_SCROLL_EN scrolls BARS/CHECKER
//               left by one pixel per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_patterngen_multi
    import vga_pattern_pkg::*;
#(
    parameter int COLOR_W    = 3,
    parameter int STEP       = 31,
    parameter int BAR_W      = 80,
    parameter int CHECK_LOG2 = 5,
    parameter int GRAD_SHIFT = 4,
    parameter int H_CTR_W    = 11,
    parameter int V_CTR_W    = 10
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_DE,
    input  logic               i_HSync,
    input  logic               i_VSync,
    input  logic [1:0]         i_Mode,
    output logic               o_DE,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic [COLOR_W-1:0] o_R,
    output logic [COLOR_W-1:0] o_G,
    output logic [COLOR_W-1:0] o_B
);

    localparam int                 STEP_W      = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [COLOR_W-1:0] c_FULL      = {COLOR_W{1'b1}};
    localparam logic [STEP_W-1:0]  c_STEP_LAST = STEP_W'(STEP - 1);

    logic [H_CTR_W-1:0] w_x;
    logic [H_CTR_W-1:0] w_xe;
    logic [V_CTR_W-1:0] w_y;
    logic               w_frame_start;
    logic               w_unused_x;

    mode_e              r_mode;
    logic [COLOR_W-1:0] r_ramp_r;
    logic [COLOR_W-1:0] r_ramp_g;
    logic [COLOR_W-1:0] r_ramp_b;
    logic [STEP_W-1:0]  r_step;

    logic [2:0]         w_bar_idx;
    logic [2:0]         w_bar_rgb;
    logic               w_check;
    logic [COLOR_W-1:0] w_grey;
    logic [COLOR_W-1:0] w_pix_r;
    logic [COLOR_W-1:0] w_pix_g;
    logic [COLOR_W-1:0] w_pix_b;

    vga_raster_tracker #(
        .H_CTR_W (H_CTR_W),
        .V_CTR_W (V_CTR_W)
    ) u_tracker (
        .i_Clk         (i_Clk),
        .i_Rst_n       (i_Rst_n),
        .i_DE          (i_DE),
        .i_HSync       (i_HSync),
        .i_VSync       (i_VSync),
        .o_X           (w_x),
        .o_Xe          (w_xe),
        .o_Y           (w_y),
        .o_Frame_Start (w_frame_start)
    );

    // Raw x is exported by the tracker for observability; patterns use xe
    assign w_unused_x = ^w_x;

    // Pattern selection is sampled only at the start of a frame
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_mode <= MODE_RAMP;
        end else if (w_frame_start) begin
            r_mode <= mode_e'(i_Mode);
        end
    end

    // Ramp: restart at full white each line, step one channel down every STEP pixels
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_ramp_r <= c_FULL;
            r_ramp_g <= c_FULL;
            r_ramp_b <= c_FULL;
            r_step   <= '0;
        end else if (!i_HSync) begin
            r_ramp_r <= c_FULL;
            r_ramp_g <= c_FULL;
            r_ramp_b <= c_FULL;
            r_step   <= '0;
        end else if (i_DE) begin
            if (r_step == c_STEP_LAST) begin
                r_step <= '0;
                if (r_ramp_r != '0) begin
                    r_ramp_r <= r_ramp_r - COLOR_W'(1);
                end else if (r_ramp_g != '0) begin
                    r_ramp_g <= r_ramp_g - COLOR_W'(1);
                end else if (r_ramp_b != '0) begin
                    r_ramp_b <= r_ramp_b - COLOR_W'(1);
                end
            end else begin
                r_step <= r_step + STEP_W'(1);
            end
        end
    end

    // Bar index counts the bar boundaries at or left of xe, saturating at 7
    always_comb begin
        w_bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (int'(w_xe) >= k * BAR_W) begin
                w_bar_idx = w_bar_idx + 3'd1;
            end
        end
    end

    assign w_bar_rgb = BAR_RGB[w_bar_idx];
    assign w_check   = w_xe[CHECK_LOG2] ^ w_y[CHECK_LOG2];
    assign w_grey    = w_y[GRAD_SHIFT +: COLOR_W];

    // Pattern mux for the pixel presented on the inputs this cycle
    always_comb begin
        w_pix_r = '0;
        w_pix_g = '0;
        w_pix_b = '0;
        case (r_mode)
            MODE_RAMP: begin
                w_pix_r = r_ramp_r;
                w_pix_g = r_ramp_g;
                w_pix_b = r_ramp_b;
            end
            MODE_BARS: begin
                w_pix_r = {COLOR_W{w_bar_rgb[2]}};
                w_pix_g = {COLOR_W{w_bar_rgb[1]}};
                w_pix_b = {COLOR_W{w_bar_rgb[0]}};
            end
            MODE_CHECKER: begin
                w_pix_r = w_check ? '0 : c_FULL;
                w_pix_g = w_check ? '0 : c_FULL;
                w_pix_b = w_check ? '0 : c_FULL;
            end
            MODE_VGRAD: begin
                w_pix_r = w_grey;
                w_pix_g = w_grey;
                w_pix_b = w_grey;
            end
            default: begin
                w_pix_r = '0;
                w_pix_g = '0;
                w_pix_b = '0;
            end
        endcase
    end

    // Output stage: colour and strobes move together; blanking forces black
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_DE    <= 1'b0;
            o_HSync <= 1'b1;
            o_VSync <= 1'b1;
            o_R     <= '0;
            o_G     <= '0;
            o_B     <= '0;
        end else begin
            o_DE    <= i_DE;
            o_HSync <= i_HSync;
            o_VSync <= i_VSync;
            o_R     <= i_DE ? w_pix_r : '0;
            o_G     <= i_DE ? w_pix_g : '0;
            o_B     <= i_DE ? w_pix_b : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_patterngen_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_patterngen_multi
// Description : Directed self-checking bench for vga_patterngen_multi.
//               Covers reset values, all four patterns, mode latching at the
//               frame boundary, mid-line asynchronous reset and (when
//               VGA_PATTERN_SCROLL_EN is defined) the per-frame scroll.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_patterngen_multi;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          de;
    logic          hs;
    logic          vs;
    logic [1:0]    mode;
    logic          o_de;
    logic          o_hs;
    logic          o_vs;
    logic [CW-1:0] o_r;
    logic [CW-1:0] o_g;
    logic [CW-1:0] o_b;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            fcnt  = 0;
    logic [8:0]    pix [0:1023];

    always #5 clk = ~clk;

    vga_patterngen_multi #(
        .COLOR_W    (CW),
        .STEP       (31),
        .BAR_W      (80),
        .CHECK_LOG2 (5),
        .GRAD_SHIFT (4),
        .H_CTR_W    (11),
        .V_CTR_W    (10)
    ) dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .i_DE    (de),
        .i_HSync (hs),
        .i_VSync (vs),
        .i_Mode  (mode),
        .o_DE    (o_de),
        .o_HSync (o_hs),
        .o_VSync (o_vs),
        .o_R     (o_r),
        .o_G     (o_g),
        .o_B     (o_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of strobes; returns 1 ns after the capturing edge
    task automatic cyc(input logic d, input logic h, input logic v);
        de = d;
        hs = h;
        vs = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        rst_n = 1'b1;
        fcnt  = 0;
    endtask

    task automatic frame_start();
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 1);
        fcnt++;
    endtask

    // HSync pulse, back porch, npix active pixels (captured), one front-porch cycle
    task automatic run_line(input int npix);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        for (int i = 0; i < npix; i++) begin
            cyc(1, 1, 1);
            pix[i] = {o_r, o_g, o_b};
        end
        cyc(0, 1, 1);
    endtask

    // Ramp: floor(p/31) decrements spent on R, then G, then B
    function automatic logic [8:0] ramp_exp(input int p);
        int d, dr, dg, db;
        d  = p / 31;
        dr = (d > 7) ? 7 : d;  d = d - dr;
        dg = (d > 7) ? 7 : d;  d = d - dg;
        db = (d > 7) ? 7 : d;
        return {3'(7 - dr), 3'(7 - dg), 3'(7 - db)};
    endfunction

    function automatic int xe_of(input int p);
`ifdef VGA_PATTERN_SCROLL_EN
        return (p + fcnt) % 2048;
`else
        return p;
`endif
    endfunction

    function automatic logic [8:0] bar_exp(input int xe);
        int idx;
        idx = xe / 80;
        if (idx > 7) idx = 7;
        case (idx)
            0:       return 9'o777;
            1:       return 9'o770;
            2:       return 9'o077;
            3:       return 9'o070;
            4:       return 9'o707;
            5:       return 9'o700;
            6:       return 9'o007;
            default: return 9'o000;
        endcase
    endfunction

    function automatic logic [8:0] chk_exp(input int xe, input int y);
        return ((((xe >> 5) ^ (y >> 5)) & 1) != 0) ? 9'o000 : 9'o777;
    endfunction

    initial begin
        rst_n = 1'b1;
        de    = 1'b0;
        hs    = 1'b1;
        vs    = 1'b1;
        mode  = 2'd0;

        // ---------------- reset values ----------------
        #1 rst_n = 1'b0;
        #2;
        check_val("rst_rgb",   {o_r, o_g, o_b}, 0);
        check_val("rst_de",    o_de, 0);
        check_val("rst_hsync", o_hs, 1);
        check_val("rst_vsync", o_vs, 1);
        cyc(0, 1, 1);
        rst_n = 1'b1;

        // ---------------- RAMP ----------------
        mode = 2'd0;
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        check_val("vsync_delayed", o_vs, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 1);
        fcnt++;
        run_line(700);
        check_val("ramp_p0",   pix[0],   9'o777);
        check_val("ramp_p30",  pix[30],  9'o777);
        check_val("ramp_p31",  pix[31],  9'o677);
        check_val("ramp_p61",  pix[61],  9'o677);
        check_val("ramp_p62",  pix[62],  9'o577);
        check_val("ramp_p217", pix[217], ramp_exp(217));
        check_val("ramp_p434", pix[434], 9'o007);
        check_val("ramp_p650", pix[650], 9'o001);
        check_val("ramp_p651", pix[651], 9'o000);
        check_val("ramp_p699", pix[699], 9'o000);
        check_val("ramp_p500", pix[500], ramp_exp(500));
        run_line(40);
        check_val("ramp_next_p0",  pix[0],  9'o777);
        check_val("ramp_next_p31", pix[31], 9'o677);

        // ---------------- BARS ----------------
        do_reset();
        mode = 2'd1;
        frame_start();
        run_line(720);
        check_val("bars_p0",   pix[0],   bar_exp(xe_of(0)));
        check_val("bars_p79",  pix[79],  bar_exp(xe_of(79)));
        check_val("bars_p80",  pix[80],  bar_exp(xe_of(80)));
        check_val("bars_p160", pix[160], bar_exp(xe_of(160)));
        check_val("bars_p300", pix[300], bar_exp(xe_of(300)));
        check_val("bars_p559", pix[559], bar_exp(xe_of(559)));
        check_val("bars_p600", pix[600], 9'o000);
        check_val("bars_p700", pix[700], 9'o000);

        // ---------------- CHECKER ----------------
        do_reset();
        mode = 2'd2;
        frame_start();
        run_line(64);
        check_val("chk_y0_x0",  pix[0],  chk_exp(xe_of(0), 0));
        check_val("chk_y0_x32", pix[32], chk_exp(xe_of(32), 0));
        check_val("chk_y0_x40", pix[40], chk_exp(xe_of(40), 0));
        check_val("blank_rgb",  {o_r, o_g, o_b}, 0);
        check_val("blank_de",   o_de, 0);
        for (int l = 1; l < 32; l++) run_line(1);
        run_line(64);
        check_val("chk_y32_x32", pix[32], chk_exp(xe_of(32), 32));
        check_val("chk_y32_x0",  pix[0],  chk_exp(xe_of(0), 32));

        // ---------------- mode latched only at frame start ----------------
        mode = 2'd0;
        frame_start();
        run_line(40);
        check_val("sw_ramp_a", pix[31], 9'o677);
        mode = 2'd3;
        run_line(40);
        check_val("sw_still_ramp_p0",  pix[0],  9'o777);
        check_val("sw_still_ramp_p31", pix[31], 9'o677);
        frame_start();
        run_line(4);
        check_val("vgrad_y0", pix[0], 9'o000);
        for (int l = 1; l < 15; l++) run_line(4);
        run_line(4);
        check_val("vgrad_y15", pix[0], 9'o000);
        run_line(4);
        check_val("vgrad_y16", pix[0], 9'o111);

        // ---------------- asynchronous reset mid-line ----------------
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        cyc(0, 1, 1);
        for (int i = 0; i < 10; i++) cyc(1, 1, 1);
        check_val("pre_rst_rgb", {o_r, o_g, o_b}, 9'o111);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_rgb", {o_r, o_g, o_b}, 0);
        check_val("async_rst_de",  o_de, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1);
        check_val("held_rst_rgb", {o_r, o_g, o_b}, 0);
        check_val("held_rst_hs",  o_hs, 1);
        rst_n = 1'b1;
        fcnt  = 0;
        run_line(40);
        check_val("rst_mode_ramp_p0",  pix[0],  9'o777);
        check_val("rst_mode_ramp_p31", pix[31], 9'o677);

        // ---------------- scroll over five frames ----------------
        do_reset();
        mode = 2'd1;
        for (int f = 0; f < 5; f++) frame_start();
        run_line(100);
`ifdef VGA_PATTERN_SCROLL_EN
        check_val("scroll_p74", pix[74], 9'o777);
        check_val("scroll_p75", pix[75], 9'o770);
`else
        check_val("noscroll_p79", pix[79], 9'o777);
        check_val("noscroll_p80", pix[80], 9'o770);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
